// File: rtl/ha_array_accum_8x8.sv
// Sequential accumulator for four half-adder array rows (8x8 multiplier partial products).
// Optional overflow flag output enabled by defining HA_ACCUM_OVF_EN.
module ha_array_accum_8x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] product,
    output logic        out_valid,
`ifdef HA_ACCUM_OVF_EN
    output logic        ovf,
`endif
    input  logic        out_ready
);

    localparam int ACC_W = 17;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0][8:0]     t_row;
    logic [3:0][6:0]     b_row;
    logic [1:0]          cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    term;

    // Row value t + (b << 2), placed at its array weight 2^(2k).
    function automatic logic [ACC_W-1:0] shifted_row(input logic [8:0] t,
                                                     input logic [6:0] b,
                                                     input logic [1:0] k);
        logic [9:0] r;
        r = {1'b0, t} + {1'b0, b, 2'b00};
        return {7'b0, r} << {k, 1'b0};
    endfunction

    // Row capture happens only on the accepting edge; no reset needed on data.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            t_row <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
            b_row <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
        end
    end

    always_comb begin
        term = shifted_row(t_row[cnt], b_row[cnt], cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            acc   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        cnt <= 2'd0;
                    end
                end
                ACC: begin
                    acc <= acc + term;
                    cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = ACC;
            ACC:     if (cnt == 2'd3)  state_next = OUT;
            OUT:     if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign product   = acc[15:0];
`ifdef HA_ACCUM_OVF_EN
    assign ovf       = acc[16];
`endif

endmodule

// File: doc/ha_array_accum_8x8.md
HA_ARRAY_ACCUM_8X8 -- requirements
Module: ha_array_accum_8x8

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have ports ha_array_k_b, input, 7 bits, for k=0..3: carry row of half-adder array k.
REQ-004 SHALL have ports ha_array_k_t, input, 9 bits, for k=0..3: sum row of half-adder array k.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream array set valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an array set.
REQ-007 SHALL have port product, output, 16 bits: accumulated product.
REQ-008 SHALL have port out_valid, output, 1 bit: product valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts product.
REQ-010 SHALL have port ovf, output, 1 bit, present only with HA_ACCUM_OVF_EN: sum exceeded 16 bits.

Function
REQ-011 Row value SHALL be R_k = t_k + (b_k << 2), 10-bit unsigned; t_k bit i has weight 2^i, b_k bit j has weight 2^(j+2).
REQ-012 Result SHALL be P = sum over k of (R_k << 2k), computed in a 17-bit accumulator; product = P[15:0].
REQ-013 FSM SHALL have states IDLE, ACC, OUT; reset state IDLE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is OUT.
REQ-015 IDLE: on edge with in_valid=1, SHALL register all eight row inputs, clear accumulator, clear row counter cnt (2 bits), go to ACC; in_valid=0 SHALL leave state unchanged.
REQ-016 ACC: each edge SHALL add (R_cnt << 2cnt) to accumulator and increment cnt; the edge with cnt=3 SHALL go to OUT.
REQ-017 Latency SHALL be exactly 4 edges from the accepting edge to out_valid=1.
REQ-018 OUT: product SHALL hold stable while out_ready=0; edge with out_ready=1 SHALL go to IDLE.
REQ-019 No input set SHALL be accepted in ACC or OUT; back-to-back throughput is one result per 6 cycles minimum (accept, 4 ACC, OUT).
REQ-020 Input row ports SHALL be sampled only on the accepting edge; changes afterwards SHALL not affect product.
REQ-021 product SHALL be registered directly from the accumulator, with no combinational path from any input.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, cnt 0, accumulator 0, product 0, out_valid 0, ovf 0; in_ready SHALL read 1.
REQ-023 rst asserted during ACC or OUT SHALL discard the in-flight result with no out_valid pulse.
REQ-024 First accept after rst deassertion SHALL occur no earlier than the first rising edge with rst=0.

Configuration
REQ-025 Macro HA_ACCUM_OVF_EN defined: ovf port exists, equals accumulator bit 16, valid with out_valid, and reset to 0.
REQ-026 Macro HA_ACCUM_OVF_EN undefined: ovf port and its logic absent; the accumulator SHALL still be 17 bits wide.

Verification
REQ-027 All rows zero, in_valid pulse -> after 4 edges out_valid=1, product=16'h0000, ovf=0.
REQ-028 Only ha_array_0_t=9'h1FF, ha_array_0_b=7'h7F -> product=16'h03FB.
REQ-029 Only ha_array_3_t=9'h1FF, ha_array_3_b=7'h7F -> product=16'hFEC0, ovf=0.
REQ-030 All four rows t=9'h1FF, b=7'h7F -> product=16'h5257, ovf=1 (when enabled).
REQ-031 Only ha_array_1_t=9'h001, out_ready held 0 for 3 cycles -> product=16'h0004 stable, out_valid held, in_ready=0 throughout.
REQ-032 rst pulsed on the second ACC edge -> out_valid never asserts, in_ready=1 immediately, next accepted set produces its correct result.
